// File: rtl/jtframe_dwnld_pkg.sv
// Shared types for the SPI-download to SDRAM programming bridge.
//   wr_state_t   : write sequencer states (idle / wait for SDRAM / gap cycle)
//   prog_entry_t : one queued SDRAM byte write {bank, word address, data, mask}
//   byte_mask    : active-low byte-lane mask for a byte at an even/odd offset
package jtframe_dwnld_pkg;

  // Word-address width held in each queued entry. The bridge's SDRAMW
  // parameter is expected to match it; wider entries are truncated on load.
  localparam int SDRAM_AW = 23;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_GAP  = 2'd2
  } wr_state_t;

  typedef struct packed {
    logic [1:0]          ba;
    logic [SDRAM_AW-1:0] addr;
    logic [15:0]         data;
    logic [1:0]          mask;
  } prog_entry_t;

  localparam int ENTRY_W = $bits(prog_entry_t);

  // Mask is active-low: 2'b10 writes the low byte, 2'b01 the high byte.
  function automatic logic [1:0] byte_mask(input logic odd, input logic swab);
    return (odd ^ swab) ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/jtframe_prog_fifo.sv
// Small synchronous show-ahead FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din  : write request and data (ignored when full unless popping too)
//   pop        : remove the head entry (ignored when empty)
//   dout       : current head entry, valid while empty is low
//   full/empty : occupancy flags derived from a separate count register
module jtframe_prog_fifo #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/jtframe_prog_bridge.sv
// Bridge from the MiST SPI download byte stream to the SDRAM programming port.
//   clk, rst_n          : clock, asynchronous active-low reset
//   downloading         : download window from the SPI base
//   ioctl_addr/dout/wr  : byte offset, byte value, one-cycle byte strobe
//   prog_addr/data/mask : word address within bank, duplicated byte, active-low mask
//   prog_ba, prog_we    : bank select and write request (held until prog_rdy)
//   prog_rd             : always 0
//   prog_rdy            : one-cycle write-done pulse from the SDRAM controller
//   dwnld_busy          : high while downloading or while queued bytes drain
//   overflow            : sticky, a byte was dropped; cleared when a download starts
module jtframe_prog_bridge
  import jtframe_dwnld_pkg::*;
#(
  parameter int          SDRAMW    = SDRAM_AW,
  parameter int          HEADER    = 0,
  parameter logic [24:0] BA1_START = 25'h100000,
  parameter logic [24:0] BA2_START = 25'h200000,
  parameter logic [24:0] BA3_START = 25'h300000,
  parameter bit          SWAB      = 1'b0,
  parameter int          FIFO_AW   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              downloading,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              ioctl_wr,
  output logic [SDRAMW-1:0] prog_addr,
  output logic [15:0]       prog_data,
  output logic [1:0]        prog_mask,
  output logic [1:0]        prog_ba,
  output logic              prog_we,
  output logic              prog_rd,
  input  logic              prog_rdy,
  output logic              dwnld_busy,
  output logic              overflow
);

  localparam logic [24:0] HDR = 25'(HEADER);

  // ---------------- accept stage: header strip, bank decode ----------------
  logic        past_header;
  logic [24:0] offs;
  logic [24:0] rel;
  logic [1:0]  bank;
  logic        too_far;
  logic        accept;
  logic        push_req;
  logic        full_block;
  logic        push;
  logic        drop;

  generate
    if (HEADER == 0) begin : g_no_hdr
      assign past_header = 1'b1;
    end else begin : g_hdr
      assign past_header = (ioctl_addr >= HDR);
    end
  endgenerate

  assign offs = ioctl_addr - HDR;

  always_comb begin
    bank = 2'd0;
    rel  = offs;
    if (offs >= BA3_START) begin
      bank = 2'd3;
      rel  = offs - BA3_START;
    end else if (offs >= BA2_START) begin
      bank = 2'd2;
      rel  = offs - BA2_START;
    end else if (offs >= BA1_START) begin
      bank = 2'd1;
      rel  = offs - BA1_START;
    end
  end

  // Word address rel[24:1] must fit in SDRAMW bits.
  generate
    if (SDRAMW < 24) begin : g_range
      assign too_far = |rel[24:SDRAMW+1];
    end else begin : g_no_range
      assign too_far = 1'b0;
    end
  endgenerate

  prog_entry_t new_entry;
  prog_entry_t head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;
  wr_state_t   state;

  always_comb begin
    new_entry.ba   = bank;
    new_entry.addr = SDRAM_AW'(rel[24:1]);
    new_entry.data = {ioctl_dout, ioctl_dout};
    new_entry.mask = byte_mask(rel[0], SWAB);
  end

  assign accept     = ioctl_wr && downloading && past_header;
  assign push_req   = accept && !too_far;
  assign full_block = push_req && fifo_full && !pop;
  assign push       = push_req && !full_block;
  assign drop       = accept && (too_far || full_block);

  // The head leaves the FIFO as it is copied into the prog_* registers, so the
  // output register behaves as one extra slot while the SDRAM write is pending.
  assign pop = (state == ST_IDLE) && !fifo_empty;

  jtframe_prog_fifo #(
    .DW (ENTRY_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (new_entry),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------- write sequencer ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      prog_we   <= 1'b0;
      prog_addr <= '0;
      prog_data <= '0;
      prog_mask <= 2'b11;
      prog_ba   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            prog_addr <= SDRAMW'(head.addr);
            prog_data <= head.data;
            prog_mask <= head.mask;
            prog_ba   <= head.ba;
            prog_we   <= 1'b1;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (prog_rdy) begin
            prog_we <= 1'b0;
            state   <= ST_GAP;
          end
        end
        ST_GAP:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign prog_rd = 1'b0;

  // ---------------- busy / overflow ----------------
  logic downloading_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwnld_busy       <= 1'b0;
      overflow         <= 1'b0;
      downloading_prev <= 1'b0;
    end else begin
      downloading_prev <= downloading;
      if (downloading)
        dwnld_busy <= 1'b1;
      else if (fifo_empty && state == ST_IDLE)
        dwnld_busy <= 1'b0;
      // A drop in the very first cycle of a new download still gets reported.
      if (drop)
        overflow <= 1'b1;
      else if (downloading && !downloading_prev)
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtframe_prog_bridge.sv
module tb_jtframe_prog_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        downloading;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        wr0, wr1, rdy0, rdy1;

  logic [22:0] a0, a1;
  logic [15:0] d0, d1;
  logic [1:0]  m0, m1, ba0, ba1;
  logic        we0, we1, rd0, rd1, busy0, busy1, ovf0, ovf1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jtframe_prog_bridge dut0 (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(wr0),
    .prog_addr(a0), .prog_data(d0), .prog_mask(m0), .prog_ba(ba0),
    .prog_we(we0), .prog_rd(rd0), .prog_rdy(rdy0),
    .dwnld_busy(busy0), .overflow(ovf0)
  );

  jtframe_prog_bridge #(.HEADER(32'h40)) dut1 (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(wr1),
    .prog_addr(a1), .prog_data(d1), .prog_mask(m1), .prog_ba(ba1),
    .prog_we(we1), .prog_rd(rd1), .prog_rdy(rdy1),
    .dwnld_busy(busy1), .overflow(ovf1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one byte strobe starting at the current negedge.
  task automatic send(input int inst, input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    if (inst == 0) wr0 = 1'b1; else wr1 = 1'b1;
    @(negedge clk);
    wr0 = 1'b0;
    wr1 = 1'b0;
  endtask

  // Wait for prog_we, check the write, answer prog_rdy two cycles later.
  task automatic do_write(input int inst, input string tag, input logic [1:0] eba,
                          input logic [22:0] eaddr, input logic [15:0] edata,
                          input logic [1:0] emask);
    int n = 0;
    while (((inst == 0) ? we0 : we1) !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".we"},   (inst == 0) ? we0 : we1, 1);
    chk({tag, ".ba"},   (inst == 0) ? ba0 : ba1, eba);
    chk({tag, ".addr"}, (inst == 0) ? a0  : a1,  eaddr);
    chk({tag, ".data"}, (inst == 0) ? d0  : d1,  edata);
    chk({tag, ".mask"}, (inst == 0) ? m0  : m1,  emask);
    @(negedge clk);
    @(negedge clk);
    chk({tag, ".hold"}, (inst == 0) ? {we0, a0} : {we1, a1}, {1'b1, eaddr});
    if (inst == 0) rdy0 = 1'b1; else rdy1 = 1'b1;
    @(negedge clk);
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    chk({tag, ".we_off"}, (inst == 0) ? we0 : we1, 0);
    $display("write %s: ba=%0d addr=%0h data=%0h mask=%b", tag, eba, eaddr, edata, emask);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rst_n = 1'b0;
    downloading = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    wr0 = 0; wr1 = 0; rdy0 = 0; rdy1 = 0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst.we",   we0, 0);
    chk("rst.addr", a0, 0);
    chk("rst.data", d0, 0);
    chk("rst.mask", m0, 2'b11);
    chk("rst.ba",   ba0, 0);
    chk("rst.busy", busy0, 0);
    chk("rst.ovf",  ovf0, 0);
    chk("rst.rd",   rd0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // basic even/odd byte pair, HEADER=0
    downloading = 1'b1;
    send(0, 25'h0, 8'h11);
    send(0, 25'h1, 8'h22);
    chk("t1.busy", busy0, 1);
    do_write(0, "t1a", 2'd0, 23'h0, 16'h1111, 2'b10);
    do_write(0, "t1b", 2'd0, 23'h0, 16'h2222, 2'b01);

    // header strip, HEADER=0x40
    send(1, 25'h3F, 8'hAA);
    send(1, 25'h140, 8'hBB);
    do_write(1, "t2", 2'd0, 23'h80, 16'hBBBB, 2'b10);

    // bank decode
    send(0, 25'h100001, 8'h33);
    send(0, 25'h300004, 8'h44);
    do_write(0, "t3a", 2'd1, 23'h0, 16'h3333, 2'b01);
    do_write(0, "t3b", 2'd3, 23'h2, 16'h4444, 2'b10);

    // burst of 6 with prog_rdy withheld: 5 accepted, 6th dropped
    chk("t4.ovf0", ovf0, 0);
    for (int i = 0; i < 6; i++) send(0, 25'(32'h10 + i), 8'(8'h50 + i));
    chk("t4.ovf1", ovf0, 1);
    do_write(0, "t4a", 2'd0, 23'h8, 16'h5050, 2'b10);
    do_write(0, "t4b", 2'd0, 23'h8, 16'h5151, 2'b01);
    do_write(0, "t4c", 2'd0, 23'h9, 16'h5252, 2'b10);
    do_write(0, "t4d", 2'd0, 23'h9, 16'h5353, 2'b01);
    do_write(0, "t4e", 2'd0, 23'hA, 16'h5454, 2'b10);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | we0;
    end
    chk("t4.no_6th", seen, 0);

    // download end while idle, overflow sticky, then cleared by new download
    downloading = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5.busy_idle", busy0, 0);
    chk("t5.ovf_sticky", ovf0, 1);
    downloading = 1'b1;
    @(negedge clk);
    chk("t5.ovf_clr", ovf0, 0);
    chk("t5.busy_set", busy0, 1);

    // drain after downloading falls with 3 bytes queued
    send(0, 25'h20, 8'h60);
    send(0, 25'h21, 8'h61);
    send(0, 25'h22, 8'h62);
    downloading = 1'b0;
    do_write(0, "t5a", 2'd0, 23'h10, 16'h6060, 2'b10);
    chk("t5.busy_a", busy0, 1);
    do_write(0, "t5b", 2'd0, 23'h10, 16'h6161, 2'b01);
    chk("t5.busy_b", busy0, 1);
    do_write(0, "t5c", 2'd0, 23'h11, 16'h6262, 2'b10);
    chk("t5.busy_gap", busy0, 1);
    @(negedge clk);
    chk("t5.busy_idle1", busy0, 1);
    @(negedge clk);
    chk("t5.busy_fall", busy0, 0);

    // reset while a write is pending
    downloading = 1'b1;
    send(0, 25'h30, 8'h70);
    send(0, 25'h31, 8'h71);
    for (int n = 0; n < 20 && we0 !== 1'b1; n++) @(negedge clk);
    chk("t6.we_pre", we0, 1);
    rst_n = 1'b0;
    downloading = 1'b0;
    #1;
    chk("t6.we_rst", we0, 0);
    chk("t6.busy_rst", busy0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // byte offered outside the download window must be ignored too
    send(0, 25'h40, 8'h80);
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      seen = seen | we0 | busy0;
    end
    chk("t6.no_write", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
